alu_input_decoder: RTL and testbench
====================================

# alu_input_decoder

Front-end stage of `alu_top`. It receives the 16-bit header/payload instruction stream, validates the header, and buffers up to 63 operands. It then hands the execution core one header beat followed by the operands, one per handshake. The input stream has no backpressure, so this block absorbs exactly one packet at a time and reports any stream violations through sticky flags.

## Interface
- `DATA_W`, default 16: bus width of input and operand data.
- `MAX_OPS`, default 63: operand buffer depth; equals the largest count that fits the 6-bit count field.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in DATA_W: header or payload word.
- `valid_in` in 1: `data_in` qualifier.
- `cmd_in` in 1: 1 marks a header beat, 0 marks a payload beat.
- `hdr_valid` out 1: decoded header available.
- `hdr_ready` in 1: core accepts the header.
- `hdr_opcode` out 4: header bits [9:6].
- `hdr_count` out 6: header bits [5:0].
- `hdr_err` out 1: illegal header; no operands follow.
- `opd_valid` out 1: operand available.
- `opd_ready` in 1: core accepts the operand.
- `opd_data` out DATA_W: operand, in arrival order.
- `opd_last` out 1: final operand of the packet.
- `busy` out 1: state is not IDLE.
- `proto_err` out 1: sticky; a stream violation was seen.
- `drop_err` out 1: sticky; a word arrived while the block was not collecting.

## Operation
- Header layout:
  - [5:0] operand count N.
  - [9:6] opcode: ADD=0, AND=1, OR=2, XOR=3, NOT=4, INC=5, DEC=6, NEG=7.
  - [15:10] reserved; ignored.
- Legality rules:
  - Opcodes 0–3 are legal only with N≥1.
  - Opcodes 4–7 are legal only with N==1.
  - Opcodes 8–15 are always illegal.
  - `hdr_err` = NOT legal.
- States: IDLE, COLLECT, HDR, DRAIN.
- IDLE:
  - `valid_in & cmd_in`: capture opcode and N, compute err, clear the write pointer.
  - If N==0, go to HDR; otherwise go to COLLECT.
  - `valid_in & !cmd_in`: word dropped, set `drop_err`.
- COLLECT:
  - Each `valid_in & !cmd_in` writes `buf[wr_ptr]` and increments `wr_ptr`.
  - When the write pointer reaches N-1, go to HDR.
  - Cycles with `valid_in=0` are gaps; remain in COLLECT.
  - Payload is stored even when err=1; it is discarded later.
  - `valid_in & cmd_in` (header arrives mid-packet): set `proto_err`, discard the partial packet, restart capture with the new header exactly as in IDLE.
- HDR:
  - `hdr_valid=1`; the hdr fields are stable until `hdr_valid & hdr_ready`.
  - On handshake: if err=1 or N==0, go to IDLE; otherwise go to DRAIN with the read pointer at 0.
- DRAIN:
  - `opd_valid=1`, `opd_data=buf[rd_ptr]`, `opd_last=(rd_ptr==N-1)`.
  - Each `opd_valid & opd_ready` increments the read pointer.
  - The handshake with `opd_last=1` returns the block to IDLE.
- In HDR and DRAIN, any `valid_in` word is dropped and sets `drop_err`.
- `proto_err` and `drop_err` clear only on reset.
- Asserting `rst_n` mid-packet abandons all buffered state.

## Timing
- Reset values:
  - `hdr_valid`, `hdr_err`, `opd_valid`, `opd_last`, `busy`, `proto_err`, `drop_err` = 0.
  - `hdr_opcode`, `hdr_count`, `opd_data` = 0.
  - State IDLE; both pointers 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Latency:
  - The header is sampled at edge T0.
  - The last payload word is sampled at edge Tk.
  - `hdr_valid` is high from Tk+1.
  - With N==0, `hdr_valid` is high from T0+1.
- With `hdr_ready` held high, the header handshake completes at the first edge `hdr_valid` is high.
- `opd_valid` rises on the edge after the header handshake.
- With `opd_ready` held high, N operands take N cycles; `busy` falls on the edge after the `opd_last` handshake.
- The next header is accepted on the first cycle `busy=0`.
- A header in the same cycle as the IDLE return edge is dropped, because the state is still DRAIN at that edge.
- Stalls: `opd_ready=0` or `hdr_ready=0` holds all outputs unchanged with no loss.

## Test plan
- ADD with two operands:
  - Stimulus: header 0x0002, payload 0x00A0, 0x000C; hold both readies high.
  - Response: hdr {opcode 0, count 2, err 0}; operands 0x00A0 then 0x000C; `opd_last` on the second operand.
- NOT with two operands (illegal):
  - Stimulus: header 0x0102, payload 0x1111, 0x2222.
  - Response: `hdr_err=1`, `hdr_count=2`; no `opd_valid`; back to IDLE.
- Maximum count with backpressure:
  - Stimulus: header 0x003F with 63 payload words 0..62; toggle `opd_ready` every cycle.
  - Response: all 63 operands delivered in order; `opd_last` only on value 62.
- Header mid-packet:
  - Stimulus: header 0x0003, one payload word, then header 0x0141 and payload 0x0005.
  - Response: `proto_err=1`; a single packet is issued: hdr {opcode 5, count 1}, operand 0x0005.
- Words while not collecting:
  - Stimulus: a payload word in IDLE, then another word while `hdr_ready=0` in HDR.
  - Response: `drop_err=1`; the issued packet is unaffected.
- Reset mid-packet:
  - Stimulus: pulse `rst_n` low during DRAIN.
  - Response: all outputs 0 immediately; the next header 0x0001 with payload 0x0120 issues normally.

Source files
------------

// File: rtl/alu_input_decoder.sv
// alu_input_decoder
//   Front-end stage of alu_top. Validates a header beat from a 16-bit
//   header/payload stream, buffers up to MAX_OPS operands, then presents
//   one header beat followed by the operands to the execution core.
//   The input stream has no backpressure, so stream violations are
//   recorded in sticky flags instead of being stalled.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   data_in/valid_in      input word and its qualifier
//   cmd_in                1 = header beat, 0 = payload beat
//   hdr_valid/hdr_ready   header handshake to the core
//   hdr_opcode/hdr_count  decoded header fields ([9:6] / [5:0])
//   hdr_err               illegal header; no operands follow
//   opd_valid/opd_ready   operand handshake to the core
//   opd_data/opd_last     operand word, final-operand marker
//   busy                  block is not idle
//   proto_err             sticky: header arrived mid-packet
//   drop_err              sticky: word arrived while not collecting
module alu_input_decoder #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_OPS = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              cmd_in,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [3:0]        hdr_opcode,
    output logic [5:0]        hdr_count,
    output logic              hdr_err,
    output logic              opd_valid,
    input  logic              opd_ready,
    output logic [DATA_W-1:0] opd_data,
    output logic              opd_last,
    output logic              busy,
    output logic              proto_err,
    output logic              drop_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HDR,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        opcode_q;
    logic [5:0]        count_q;
    logic              err_q;
    logic [5:0]        wr_ptr_q;
    logic [5:0]        rd_ptr_q;
    logic              proto_err_q;
    logic              drop_err_q;
    logic [DATA_W-1:0] mem_q [MAX_OPS];

    logic              hdr_take;
    logic              pay_take;
    logic              last_w;

    // Unary opcodes (4-7) take exactly one operand, binary ones at least one.
    function automatic logic hdr_legal(input logic [3:0] op, input logic [5:0] n);
        if (op < 4'd4)      return n != 6'd0;
        else if (op < 4'd8) return n == 6'd1;
        else                return 1'b0;
    endfunction

    // A header restarts capture from both IDLE and COLLECT.
    assign hdr_take = valid_in && cmd_in &&
                      (state_q == S_IDLE || state_q == S_COLLECT);
    assign pay_take = valid_in && !cmd_in && (state_q == S_COLLECT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (hdr_take)
                    state_d = (data_in[5:0] == 6'd0) ? S_HDR : S_COLLECT;
            end
            S_COLLECT: begin
                if (hdr_take)
                    state_d = (data_in[5:0] == 6'd0) ? S_HDR : S_COLLECT;
                else if (pay_take && wr_ptr_q == count_q - 6'd1)
                    state_d = S_HDR;
            end
            S_HDR: begin
                if (hdr_ready)
                    state_d = (err_q || count_q == 6'd0) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (opd_ready && last_w)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Header fields, pointers and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            proto_err_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            if (hdr_take) begin
                opcode_q <= data_in[9:6];
                count_q  <= data_in[5:0];
                err_q    <= !hdr_legal(data_in[9:6], data_in[5:0]);
                wr_ptr_q <= '0;
            end else if (pay_take) begin
                wr_ptr_q <= wr_ptr_q + 6'd1;
            end

            if (state_q == S_HDR && hdr_ready)
                rd_ptr_q <= '0;
            else if (state_q == S_DRAIN && opd_ready)
                rd_ptr_q <= rd_ptr_q + 6'd1;

            if (valid_in && cmd_in && state_q == S_COLLECT)
                proto_err_q <= 1'b1;

            if (valid_in && (state_q == S_HDR || state_q == S_DRAIN ||
                             (state_q == S_IDLE && !cmd_in)))
                drop_err_q <= 1'b1;
        end
    end

    // Operand storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (pay_take)
            mem_q[wr_ptr_q] <= data_in;
    end

    // Outputs, decoded from registered state only
    always_comb begin
        last_w     = (state_q == S_DRAIN) && (rd_ptr_q == count_q - 6'd1);
        hdr_valid  = (state_q == S_HDR);
        hdr_opcode = opcode_q;
        hdr_count  = count_q;
        hdr_err    = err_q;
        opd_valid  = (state_q == S_DRAIN);
        opd_data   = (state_q == S_DRAIN) ? mem_q[rd_ptr_q] : '0;
        opd_last   = last_w;
        busy       = (state_q != S_IDLE);
        proto_err  = proto_err_q;
        drop_err   = drop_err_q;
    end

endmodule

// File: tb/tb_alu_input_decoder.sv
// tb_alu_input_decoder
//   Directed bench for alu_input_decoder: reset state, legal and illegal
//   packets, maximum count with operand backpressure, header mid-packet,
//   dropped words with header stall, and reset during drain.
module tb_alu_input_decoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        valid_in;
    logic        cmd_in;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [3:0]  hdr_opcode;
    logic [5:0]  hdr_count;
    logic        hdr_err;
    logic        opd_valid;
    logic        opd_ready;
    logic [15:0] opd_data;
    logic        opd_last;
    logic        busy;
    logic        proto_err;
    logic        drop_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu_input_decoder #(.DATA_W(16), .MAX_OPS(63)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .cmd_in    (cmd_in),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_opcode(hdr_opcode),
        .hdr_count (hdr_count),
        .hdr_err   (hdr_err),
        .opd_valid (opd_valid),
        .opd_ready (opd_ready),
        .opd_data  (opd_data),
        .opd_last  (opd_last),
        .busy      (busy),
        .proto_err (proto_err),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic is_hdr, input logic [15:0] w);
        valid_in = 1'b1;
        cmd_in   = is_hdr;
        data_in  = w;
        tick();
        valid_in = 1'b0;
        cmd_in   = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        int unsigned idx;
        rst_n     = 1'b0;
        data_in   = '0;
        valid_in  = 1'b0;
        cmd_in    = 1'b0;
        hdr_ready = 1'b0;
        opd_ready = 1'b0;

        // Reset state
        #2;
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_opd_valid", opd_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_flags",     {proto_err, drop_err, hdr_err, opd_last}, 0);
        check("rst_fields",    {hdr_opcode, hdr_count, opd_data}, 0);
        #1 rst_n = 1'b1;
        hdr_ready = 1'b1;
        opd_ready = 1'b1;

        // ADD, two operands, readies held high
        send(1'b1, 16'h0002);
        check("add_busy_collect", busy, 1);
        check("add_no_hdr_yet", hdr_valid, 0);
        send(1'b0, 16'h00A0);
        check("add_still_collect", hdr_valid, 0);
        send(1'b0, 16'h000C);
        check("add_hdr_valid", hdr_valid, 1);
        check("add_hdr_fields", {hdr_err, hdr_opcode, hdr_count}, {1'b0, 4'd0, 6'd2});
        tick();
        check("add_op0_valid", opd_valid, 1);
        check("add_op0_data",  opd_data, 16'h00A0);
        check("add_op0_last",  opd_last, 0);
        check("add_hdr_gone",  hdr_valid, 0);
        tick();
        check("add_op1_data",  opd_data, 16'h000C);
        check("add_op1_last",  opd_last, 1);
        tick();
        check("add_idle", {busy, opd_valid}, 0);

        // NOT with two operands is illegal
        send(1'b1, 16'h0102);
        send(1'b0, 16'h1111);
        send(1'b0, 16'h2222);
        check("not_hdr_valid", hdr_valid, 1);
        check("not_hdr_fields", {hdr_err, hdr_opcode, hdr_count}, {1'b1, 4'd4, 6'd2});
        tick();
        check("not_no_opd", opd_valid, 0);
        check("not_idle", busy, 0);

        // Maximum count, opd_ready toggling every cycle
        send(1'b1, 16'h003F);
        for (int i = 0; i < 63; i++) send(1'b0, 16'(i));
        check("max_hdr_valid", hdr_valid, 1);
        check("max_hdr_fields", {hdr_err, hdr_opcode, hdr_count}, {1'b0, 4'd0, 6'd63});
        tick();
        idx = 0;
        for (int cyc = 0; cyc < 300 && idx < 63; cyc++) begin
            opd_ready = cyc[0];
            check("max_opd_valid", opd_valid, 1);
            check("max_opd_data",  opd_data, idx);
            check("max_opd_last",  opd_last, (idx == 62) ? 1 : 0);
            if (opd_ready) idx++;
            tick();
        end
        check("max_all_delivered", idx, 63);
        check("max_idle", {busy, opd_valid}, 0);
        opd_ready = 1'b1;

        // Header mid-packet restarts capture
        check("mid_proto_before", proto_err, 0);
        send(1'b1, 16'h0003);
        send(1'b0, 16'h1234);
        send(1'b1, 16'h0141);
        check("mid_proto_set", proto_err, 1);
        check("mid_no_hdr_yet", hdr_valid, 0);
        send(1'b0, 16'h0005);
        check("mid_hdr_valid", hdr_valid, 1);
        check("mid_hdr_fields", {hdr_err, hdr_opcode, hdr_count}, {1'b0, 4'd5, 6'd1});
        tick();
        check("mid_opd", {opd_valid, opd_last, opd_data}, {1'b1, 1'b1, 16'h0005});
        tick();
        check("mid_idle", busy, 0);

        // Words while not collecting; header stalled in HDR
        check("drop_before", drop_err, 0);
        send(1'b0, 16'h7777);
        check("drop_idle_set", drop_err, 1);
        check("drop_idle_busy", busy, 0);
        hdr_ready = 1'b0;
        send(1'b1, 16'h0001);
        send(1'b0, 16'h0042);
        check("drop_hdr_valid", hdr_valid, 1);
        send(1'b0, 16'h9999);
        check("drop_hdr_stall", {hdr_valid, hdr_err, hdr_opcode, hdr_count}, {1'b1, 1'b0, 4'd0, 6'd1});
        tick();
        check("drop_hdr_held", hdr_valid, 1);
        hdr_ready = 1'b1;
        tick();
        check("drop_opd", {opd_valid, opd_last, opd_data}, {1'b1, 1'b1, 16'h0042});
        tick();
        check("drop_idle", busy, 0);

        // Reset during DRAIN
        send(1'b1, 16'h0002);
        send(1'b0, 16'h0001);
        send(1'b0, 16'h0002);
        tick();
        check("rstm_draining", {opd_valid, opd_data}, {1'b1, 16'h0001});
        rst_n = 1'b0;
        #1;
        check("rstm_outputs", {hdr_valid, opd_valid, busy, hdr_err, opd_last}, 0);
        check("rstm_flags", {proto_err, drop_err}, 0);
        check("rstm_fields", {hdr_opcode, hdr_count, opd_data}, 0);
        #1 rst_n = 1'b1;
        send(1'b1, 16'h0001);
        send(1'b0, 16'h0120);
        check("rstm_hdr", {hdr_valid, hdr_err, hdr_opcode, hdr_count}, {1'b1, 1'b0, 4'd0, 6'd1});
        tick();
        check("rstm_opd", {opd_valid, opd_last, opd_data}, {1'b1, 1'b1, 16'h0120});
        tick();
        check("rstm_idle", {busy, proto_err, drop_err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
